// File: rtl/mmio_pkg.sv
// mmio_pkg: shared MMIO defines and arbiter types
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
package mmio_pkg;
  typedef enum logic {IDLE, HOLD} arb_state_t;
  typedef logic mid_t;
  localparam int CNT_W = 16;
endpackage

// File: rtl/mmio_arb_pick.sv
// mmio_arb_pick: 2-way grant picker, fixed priority or round-robin against last_grant
module mmio_arb_pick
  import mmio_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  mid_t last_grant,
  input  logic rr_en,
  output mid_t grant,
  output logic valid
);
  assign valid = req0 | req1;
  assign grant = (req0 && req1) ? (rr_en && !last_grant) : (req1 && !req0);
endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-master MMIO arbiter with hold/timeout FSM; define MMIO_ARB_RR_EN for round-robin, else master 0 has fixed priority
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m0_req,
  input  logic m0_we,
  input  logic [`ADDR_W-1:0] m0_addr,
  input  logic [`XLEN-1:0] m0_wdata,
  output logic m0_ready,
  output logic [`XLEN-1:0] m0_rdata,
  input  logic m1_req,
  input  logic m1_we,
  input  logic [`ADDR_W-1:0] m1_addr,
  input  logic [`XLEN-1:0] m1_wdata,
  output logic m1_ready,
  output logic [`XLEN-1:0] m1_rdata,
  output logic s_req,
  output logic s_we,
  output logic [`ADDR_W-1:0] s_addr,
  output logic [`XLEN-1:0] s_wdata,
  input  logic s_ready,
  input  logic [`XLEN-1:0] s_rdata,
  output logic err_timeout
);
`ifdef MMIO_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif
  arb_state_t state, state_nx;
  mid_t lock, last_grant, rsp_owner, pick_id, sel;
  logic pick_vld, rsp_zero, rsp_vld, req_l, tmo, fire;
  logic [CNT_W-1:0] cnt;
  mmio_arb_pick u_pick (
    .req0(m0_req),
    .req1(m1_req),
    .last_grant(last_grant),
    .rr_en(RR_EN),
    .grant(pick_id),
    .valid(pick_vld)
  );
  always_comb begin
    sel = state == HOLD ? lock : pick_id;
    req_l = pick_vld && (sel ? m1_req : m0_req);
    tmo = state == HOLD && TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TIMEOUT_CYCLES);
    s_req = rst_n && req_l && !tmo;
    fire = rst_n && req_l && (tmo || s_ready);
    m0_ready = fire && !sel;
    m1_ready = fire && sel;
    s_we = s_req && (sel ? m1_we : m0_we);
    s_addr = s_req ? (sel ? m1_addr : m0_addr) : '0;
    s_wdata = s_req ? (sel ? m1_wdata : m0_wdata) : '0;
    state_nx = state == IDLE ? ((s_req && !s_ready) ? HOLD : IDLE) : ((fire || !req_l) ? IDLE : HOLD);
    m0_rdata = (rsp_vld && !rsp_owner && !rsp_zero) ? s_rdata : '0;
    m1_rdata = (rsp_vld && rsp_owner && !rsp_zero) ? s_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lock <= '0;
      cnt <= '0;
      rsp_owner <= '0;
      rsp_zero <= 1'b0;
      rsp_vld <= 1'b0;
      err_timeout <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      lock <= state == IDLE ? sel : lock;
      cnt <= state == IDLE ? '0 : cnt + CNT_W'(~&cnt);
      rsp_vld <= fire;
      rsp_owner <= fire ? sel : rsp_owner;
      rsp_zero <= fire ? tmo : rsp_zero;
      last_grant <= fire ? sel : last_grant;
      err_timeout <= err_timeout | (fire && tmo);
    end
  end
endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: directed scoreboard bench for mmio_arbiter (TIMEOUT_CYCLES=4)
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
module tb_mmio_arbiter;
  import mmio_pkg::*;
`ifdef MMIO_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [`ADDR_W-1:0] LED = 'h4000_0010;
  logic clk = 1'b0, rst_n;
  logic m0_req, m0_we, m1_req, m1_we, m0_ready, m1_ready;
  logic [`ADDR_W-1:0] m0_addr, m1_addr, s_addr;
  logic [`XLEN-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic s_req, s_we, s_ready, rdy_v, tie, err_timeout;
  int checks = 0, failures = 0;
  typedef struct {string tag; logic [63:0] val;} exp_t;
  exp_t sb[$];
  assign s_ready = tie ? s_req : rdy_v;
  always #5 clk = ~clk;
  mmio_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .err_timeout(err_timeout)
  );
  task automatic exp(input string tag, input logic [63:0] val);
    sb.push_back('{tag, val});
  endtask
  task automatic chk(input string tag, input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, observed=%0h", tag, obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val && tag == e.tag) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (entry %s)", tag, obs, e.val, e.tag);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; tie = 1'b0; rdy_v = 1'b1; s_rdata = 'hAAAA_AAAA;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    exp("rst_m0_ready", 0); exp("rst_m1_ready", 0); exp("rst_s_req", 0);
    exp("rst_m0_rdata", 0); exp("rst_m1_rdata", 0); exp("rst_err", 0);
    smp();
    chk("rst_m0_ready", m0_ready); chk("rst_m1_ready", m1_ready); chk("rst_s_req", s_req);
    chk("rst_m0_rdata", m0_rdata); chk("rst_m1_rdata", m1_rdata); chk("rst_err", err_timeout);
    #2; m0_req = 1'b0; m1_req = 1'b0; rst_n = 1'b1;
    // m0 write to the LED register with ready tied to s_req
    cyc(); tie = 1'b1; m0_req = 1'b1; m0_we = 1'b1; m0_addr = LED; m0_wdata = 'hCAFE_F00D;
    exp("wr_m0_ready", 1); exp("wr_m1_ready", 0); exp("wr_s_we", 1);
    exp("wr_s_addr", LED); exp("wr_s_wdata", 'hCAFE_F00D);
    smp();
    chk("wr_m0_ready", m0_ready); chk("wr_m1_ready", m1_ready); chk("wr_s_we", s_we);
    chk("wr_s_addr", s_addr); chk("wr_s_wdata", s_wdata);
    cyc(); m0_req = 1'b0; m0_we = 1'b0; exp("wr_state", IDLE); exp("idle_s_addr", 0);
    smp(); chk("wr_state", dut.state); chk("idle_s_addr", s_addr);
    // m1 read stalled three cycles, m0 arriving mid-hold
    cyc(); tie = 1'b0; rdy_v = 1'b0; m1_req = 1'b1; m1_addr = 'h20;
    exp("rd1_s_req", 1); exp("rd1_m1_ready", 0);
    smp(); chk("rd1_s_req", s_req); chk("rd1_m1_ready", m1_ready);
    cyc(); m0_req = 1'b1; m0_addr = 'h30;
    exp("rd2_s_addr", 'h20); exp("rd2_m0_ready", 0); exp("rd2_m1_ready", 0);
    smp(); chk("rd2_s_addr", s_addr); chk("rd2_m0_ready", m0_ready); chk("rd2_m1_ready", m1_ready);
    cyc(); exp("rd3_m1_ready", 0); exp("rd3_m0_ready", 0);
    smp(); chk("rd3_m1_ready", m1_ready); chk("rd3_m0_ready", m0_ready);
    cyc(); rdy_v = 1'b1; exp("rd4_m1_ready", 1); exp("rd4_m0_ready", 0);
    smp(); chk("rd4_m1_ready", m1_ready); chk("rd4_m0_ready", m0_ready);
    cyc(); m1_req = 1'b0; s_rdata = 'h1234_5678;
    exp("rd5_m1_rdata", 'h1234_5678); exp("rd5_m0_rdata", 0); exp("rd5_m0_ready", 1);
    smp(); chk("rd5_m1_rdata", m1_rdata); chk("rd5_m0_rdata", m0_rdata); chk("rd5_m0_ready", m0_ready);
    cyc(); m0_req = 1'b0; s_rdata = 'h0BAD_F00D;
    exp("rd6_m0_rdata", 'h0BAD_F00D); exp("rd6_m1_rdata", 0);
    smp(); chk("rd6_m0_rdata", m0_rdata); chk("rd6_m1_rdata", m1_rdata);
    cyc(); m1_req = 1'b1; m1_we = 1'b1; exp("m1wr_ready", 1);
    smp(); chk("m1wr_ready", m1_ready);
    // continuous contention, last accepted grant was m1
    cyc(); tie = 1'b1; m1_we = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      exp("arb_m0_ready", RR ? (i % 2 == 0) : 1'b1);
      exp("arb_m1_ready", RR ? (i % 2 == 1) : 1'b0);
      smp(); chk("arb_m0_ready", m0_ready); chk("arb_m1_ready", m1_ready);
    end
    cyc(); tie = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    // timeout: one locking cycle, four stalled hold cycles, forced completion on the fifth
    cyc(); rdy_v = 1'b0; m0_req = 1'b1; m0_addr = 'h44;
    exp("to_lock_ready", 0); smp(); chk("to_lock_ready", m0_ready);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      exp("to_m0_ready", i == 5); exp("to_s_req", i != 5); exp("to_err_pre", 0);
      smp(); chk("to_m0_ready", m0_ready); chk("to_s_req", s_req); chk("to_err_pre", err_timeout);
    end
    cyc(); m0_req = 1'b0; s_rdata = 'hFFFF_FFFF;
    exp("to_rdata", 0); exp("to_err", 1); exp("to_ready_once", 0);
    smp(); chk("to_rdata", m0_rdata); chk("to_err", err_timeout); chk("to_ready_once", m0_ready);
    cyc(); rdy_v = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
    exp("to_next_ready", 1); exp("to_err_sticky", 1);
    smp(); chk("to_next_ready", m1_ready); chk("to_err_sticky", err_timeout);
    cyc(); m1_req = 1'b0; m1_we = 1'b0; exp("to_err_sticky2", 1);
    smp(); chk("to_err_sticky2", err_timeout);
    // abort: locked m0 drops req, pending m1 takes over
    cyc(); rdy_v = 1'b0; m0_req = 1'b1; exp("ab_lock_ready", 0);
    smp(); chk("ab_lock_ready", m0_ready);
    cyc(); m1_req = 1'b1; exp("ab_hold_m1_ready", 0);
    smp(); chk("ab_hold_m1_ready", m1_ready);
    cyc(); m0_req = 1'b0;
    exp("ab_m0_ready", 0); exp("ab_m1_ready", 0); exp("ab_s_req", 0);
    smp(); chk("ab_m0_ready", m0_ready); chk("ab_m1_ready", m1_ready); chk("ab_s_req", s_req);
    cyc(); rdy_v = 1'b1; exp("ab_next_m1_ready", 1);
    smp(); chk("ab_next_m1_ready", m1_ready);
    // reset asserted while m1 is held
    cyc(); rdy_v = 1'b0; exp("hr_lock_ready", 0);
    smp(); chk("hr_lock_ready", m1_ready);
    cyc(); rdy_v = 1'b1; m0_req = 1'b1; rst_n = 1'b0;
    exp("hr_m1_ready", 0); exp("hr_m0_ready", 0); exp("hr_s_req", 0); exp("hr_err", 0);
    smp(); chk("hr_m1_ready", m1_ready); chk("hr_m0_ready", m0_ready); chk("hr_s_req", s_req); chk("hr_err", err_timeout);
    #2; rst_n = 1'b1;
    cyc(); exp("hr_first_m0", 1); exp("hr_first_m1", 0);
    smp(); chk("hr_first_m0", m0_ready); chk("hr_first_m1", m1_ready);
    cyc(); m0_req = 1'b0; m1_req = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: HOLD cycles before a forced completion; 0 disables timeout; legal range 0..65535.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports m0_req/m0_we, input, 1: master 0 request and write enable.
REQ-005 SHALL have ports m0_addr, input, `ADDR_W, and m0_wdata, input, `XLEN: master 0 address and write data.
REQ-006 SHALL have ports m0_ready, output, 1, and m0_rdata, output, `XLEN: master 0 acknowledge and read data.
REQ-007 SHALL have ports m1_req/m1_we/m1_addr/m1_wdata/m1_ready/m1_rdata, with directions and widths identical to master 0.
REQ-008 SHALL have ports s_req/s_we/s_addr/s_wdata as outputs and s_ready/s_rdata as inputs, widths as for master 0: shared MMIO slave port.
REQ-009 SHALL have port err_timeout, output, 1: sticky flag set on any forced completion.

Function
REQ-010 SHALL implement the FSM {IDLE, HOLD}.
REQ-011 In IDLE, SHALL select a grant combinationally among requesting masters and drive s_* from the granted master in the same cycle.
REQ-012 In IDLE, if s_ready=1 the same cycle, SHALL assert the granted master's ready combinationally (zero added latency) and remain in IDLE.
REQ-013 In IDLE, if the granted master's request sees s_ready=0, SHALL lock the grant, enter HOLD, and clear the timeout counter.
REQ-014 In HOLD, SHALL drive s_* only from the locked master and ignore the other master.
REQ-015 In HOLD, on s_ready=1 SHALL assert the locked master's ready and return to IDLE.
REQ-016 In HOLD, the counter SHALL increment by 1 per cycle (16-bit, no wrap).
REQ-017 When the counter equals TIMEOUT_CYCLES (TIMEOUT_CYCLES>0), SHALL: deassert s_req; assert the locked master's ready; set err_timeout; force the next-cycle rdata to 0; return to IDLE.
REQ-018 If the locked master drops req in HOLD, SHALL deassert s_req, assert no ready, and return to IDLE (abort).
REQ-019 An accepted transfer is one where a master sees ready. On each accepted transfer SHALL register rsp_owner (master id) and rsp_zero (1 only on timeout).
REQ-020 In the cycle after acceptance, the owner's rdata SHALL be s_rdata, or 0 if rsp_zero. The non-owner's rdata SHALL be 0 at all times.
REQ-021 A master's ready SHALL never be asserted while that master's req=0; at most one ready SHALL be high per cycle.
REQ-022 s_req=0 whenever no master is granted; s_addr/s_wdata/s_we SHALL be 0 when s_req=0.
REQ-023 Masters SHALL hold req/we/addr/wdata stable until ready. The arbiter SHALL NOT re-sample a locked master's fields except for the req abort check.

Reset
REQ-024 On rst_n=0, asynchronously: state=IDLE; counter=0; rsp_owner=0; rsp_zero=0; err_timeout=0; last_grant=1 (master 0 wins the first contention).
REQ-025 During reset, all ready outputs, s_req and all rdata outputs SHALL be 0.
REQ-026 Reset asserted in HOLD SHALL abandon the transfer with no ready to any master.
REQ-027 err_timeout SHALL clear only on reset.

Configuration
REQ-028 Macro MMIO_ARB_RR_EN defined: round-robin. On contention in IDLE, grant the master not equal to last_grant; last_grant updates only on accepted transfers.
REQ-029 Macro MMIO_ARB_RR_EN undefined: fixed priority, master 0 always wins contention; last_grant is still maintained but unused for selection.

Structure
REQ-030 mmio_pkg SHALL hold: the arb_state_t enum {IDLE, HOLD}; the master-id typedef (1 bit); the timeout counter width constant (16).
REQ-031 ADDR_W/XLEN SHALL come from the shared defines; ports SHALL use the existing MMIO request/response port macros per master.
REQ-032 SHALL contain one sub-module, mmio_arb_pick (2-way picker: inputs req0, req1, last_grant, rr_en; output grant id and valid); the FSM, counter and response steering live in the top.

Verification
REQ-033 m0 write addr LED, s_ready tied to s_req -> m0_ready same cycle, s_wdata=m0_wdata, m1_ready=0, state stays IDLE.
REQ-034 With RR enabled, m0 and m1 both request continuously for 4 cycles, ready immediate -> grants m0,m1,m0,m1. With RR disabled -> m0 in all 4 cycles.
REQ-035 m1 read, s_ready low 3 cycles then high, s_rdata=0x1234_5678 the next cycle -> m1_ready on cycle 4, m1_rdata=0x1234_5678 on cycle 5, m0_rdata=0; an m0 request raised on cycle 2 is ignored until IDLE.
REQ-036 TIMEOUT_CYCLES=4, s_ready stuck 0 -> locked master's ready pulses exactly once on the 5th cycle, s_req drops, next-cycle rdata=0, err_timeout=1 and stays 1 through later transfers.
REQ-037 rst_n pulsed low mid-HOLD -> no ready emitted, s_req=0 immediately, err_timeout=0; after release, the first contention is granted to m0.
REQ-038 Locked master drops req in HOLD -> return to IDLE with no ready, and the other pending master is granted the next cycle.
